// File: rtl/address_sequencer.sv
// Address sequencer: issues FIRST_ADDR..LAST_ADDR in increments of STEP while
// enabled, with saturate-and-finish or wrap-around end-of-range behaviour,
// synchronous clear/load, and registered status flags.
module address_sequencer #(
    parameter int ADDR_WIDTH = 4,
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 10,
    parameter int STEP       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  address_gen_enable,
    input  logic                  clear,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_value,
    input  logic                  wrap_mode,
    output logic [ADDR_WIDTH-1:0] address_counter,
    output logic                  address_valid,
    output logic                  done,
    output logic                  wrapped
);

    // All-ones is never a legal address, so it doubles as the idle marker.
    localparam logic [ADDR_WIDTH-1:0] IDLE_ADDR  = '1;
    localparam logic [ADDR_WIDTH-1:0] FIRST_A    = ADDR_WIDTH'(FIRST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_A     = ADDR_WIDTH'(LAST_ADDR);
    // One extra bit so the increment can never silently wrap before clamping.
    localparam logic [ADDR_WIDTH:0]   STEP_WIDE  = (ADDR_WIDTH+1)'(STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   address_next;
    logic                    valid_next;
    logic                    done_next;
    logic                    wrapped_next;
    logic [ADDR_WIDTH:0]     sum_wide;
    logic [ADDR_WIDTH-1:0]   step_addr;
    logic [ADDR_WIDTH-1:0]   load_clamped;

    // Next address on an enabled step: add in ADDR_WIDTH+1 bits, clamp to LAST.
    always_comb begin
        sum_wide = {1'b0, address_counter} + STEP_WIDE;
        if (int'(sum_wide) > LAST_ADDR) begin
            step_addr = LAST_A;
        end else begin
            step_addr = sum_wide[ADDR_WIDTH-1:0];
        end
    end

    // Loaded start address, forced into [FIRST_ADDR, LAST_ADDR].
    always_comb begin
        if (int'(load_value) < FIRST_ADDR) begin
            load_clamped = FIRST_A;
        end else if (int'(load_value) > LAST_ADDR) begin
            load_clamped = LAST_A;
        end else begin
            load_clamped = load_value;
        end
    end

    // Next-state and next-output logic; priority is clear > load > enable.
    always_comb begin
        state_next   = state_reg;
        address_next = address_counter;
        valid_next   = address_valid;
        done_next    = done;
        wrapped_next = 1'b0;

        if (clear) begin
            state_next   = IDLE;
            address_next = IDLE_ADDR;
            valid_next   = 1'b0;
            done_next    = 1'b0;
        end else if (load) begin
            state_next   = RUN;
            address_next = load_clamped;
            valid_next   = 1'b1;
            done_next    = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (address_gen_enable) begin
                        state_next   = RUN;
                        address_next = FIRST_A;
                        valid_next   = 1'b1;
                    end
                end
                RUN: begin
                    if (address_gen_enable) begin
                        if (address_counter == LAST_A) begin
                            // wrap_mode only matters at this decision point.
                            if (wrap_mode) begin
                                address_next = FIRST_A;
                                wrapped_next = 1'b1;
                            end else begin
                                state_next = DONE;
                                done_next  = 1'b1;
                            end
                        end else begin
                            address_next = step_addr;
                        end
                    end
                end
                DONE: begin
                    // Parked at LAST_ADDR until clear, load or reset.
                end
                default: begin
                    state_next   = IDLE;
                    address_next = IDLE_ADDR;
                    valid_next   = 1'b0;
                    done_next    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with immediate asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            address_counter <= IDLE_ADDR;
            address_valid   <= 1'b0;
            done            <= 1'b0;
            wrapped         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            address_counter <= address_next;
            address_valid   <= valid_next;
            done            <= done_next;
            wrapped         <= wrapped_next;
        end
    end

endmodule

// File: tb/tb_address_sequencer.sv
// Bench for address_sequencer: two instances (STEP=1 and STEP=3) share the
// same stimulus; a behavioural model feeds a scoreboard that a negedge
// monitor drains and compares.
module tb_address_sequencer;

    localparam int AW    = 4;
    localparam int FIRST = 0;
    localparam int LAST  = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          clear;
    logic          load;
    logic          wrap;
    logic [AW-1:0] lv;

    logic [AW-1:0] cnt_a, cnt_b;
    logic          val_a, val_b, done_a, done_b, wr_a, wr_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [AW-1:0] c;
        logic          v;
        logic          d;
        logic          w;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Model state per instance: address -1 means idle.
    int m_addr[2];
    bit m_done[2];
    bit m_wr[2];
    int m_step[2] = '{1, 3};

    always #5 clk = ~clk;

    address_sequencer #(.ADDR_WIDTH(AW), .FIRST_ADDR(FIRST), .LAST_ADDR(LAST), .STEP(1)) dut_a (
        .clk(clk), .reset(reset), .address_gen_enable(en), .clear(clear), .load(load),
        .load_value(lv), .wrap_mode(wrap), .address_counter(cnt_a), .address_valid(val_a),
        .done(done_a), .wrapped(wr_a)
    );

    address_sequencer #(.ADDR_WIDTH(AW), .FIRST_ADDR(FIRST), .LAST_ADDR(LAST), .STEP(3)) dut_b (
        .clk(clk), .reset(reset), .address_gen_enable(en), .clear(clear), .load(load),
        .load_value(lv), .wrap_mode(wrap), .address_counter(cnt_b), .address_valid(val_b),
        .done(done_b), .wrapped(wr_b)
    );

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model_out(input int i);
        exp_t e;
        e.c = (m_addr[i] < 0) ? {AW{1'b1}} : AW'(m_addr[i]);
        e.v = (m_addr[i] >= 0);
        e.d = m_done[i];
        e.w = m_wr[i];
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = -1;
            m_done[i] = 1'b0;
            m_wr[i]   = 1'b0;
        end
    endtask

    // One clock edge of the reference behaviour, from the current inputs.
    task automatic model_edge();
        int lvc;
        for (int i = 0; i < 2; i++) begin
            m_wr[i] = 1'b0;
            if (clear) begin
                m_addr[i] = -1;
                m_done[i] = 1'b0;
            end else if (load) begin
                lvc = int'(lv);
                if (lvc < FIRST) lvc = FIRST;
                if (lvc > LAST)  lvc = LAST;
                m_addr[i] = lvc;
                m_done[i] = 1'b0;
            end else if (en) begin
                if (m_addr[i] < 0) begin
                    m_addr[i] = FIRST;
                end else if (m_done[i]) begin
                    // finished: nothing moves
                end else if (m_addr[i] == LAST) begin
                    if (wrap) begin
                        m_addr[i] = FIRST;
                        m_wr[i]   = 1'b1;
                    end else begin
                        m_done[i] = 1'b1;
                    end
                end else begin
                    m_addr[i] = (m_addr[i] + m_step[i] > LAST) ? LAST : m_addr[i] + m_step[i];
                end
            end
        end
    endtask

    task automatic push_expected();
        q_a.push_back(model_out(0));
        q_b.push_back(model_out(1));
    endtask

    task automatic cycle(input bit e, input bit c, input bit l, input bit w, input logic [AW-1:0] v);
        @(negedge clk);
        en = e; clear = c; load = l; wrap = w; lv = v;
        @(posedge clk);
        #1;
        model_edge();
        push_expected();
    endtask

    task automatic check_reset_now(input string tag);
        check({tag, "_cnt_a"},  int'(cnt_a),  15);
        check({tag, "_val_a"},  int'(val_a),  0);
        check({tag, "_done_a"}, int'(done_a), 0);
        check({tag, "_wr_a"},   int'(wr_a),   0);
        check({tag, "_cnt_b"},  int'(cnt_b),  15);
        check({tag, "_val_b"},  int'(val_b),  0);
    endtask

    // Scoreboard monitor: compares each registered result away from the edge.
    always @(negedge clk) begin
        if (q_a.size() > 0 && q_b.size() > 0) begin
            exp_t ea;
            exp_t eb;
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            check("cnt_a",  int'(cnt_a),  int'(ea.c));
            check("val_a",  int'(val_a),  int'(ea.v));
            check("done_a", int'(done_a), int'(ea.d));
            check("wr_a",   int'(wr_a),   int'(ea.w));
            check("cnt_b",  int'(cnt_b),  int'(eb.c));
            check("val_b",  int'(val_b),  int'(eb.v));
            check("done_b", int'(done_b), int'(eb.d));
            check("wr_b",   int'(wr_b),   int'(eb.w));
            $display("cyc t=%0t a: cnt=%0d v=%0b d=%0b w=%0b | b: cnt=%0d v=%0b d=%0b w=%0b",
                     $time, cnt_a, val_a, done_a, wr_a, cnt_b, val_b, done_b, wr_b);
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; clear = 1'b0; load = 1'b0; wrap = 1'b0; lv = '0;
        model_reset();
        #1;
        check_reset_now("por");
        #11;
        reset = 1'b0;
        push_expected();

        // Saturating run to DONE and beyond (STEP=3 instance clamps at 10).
        for (int k = 0; k < 17; k++) cycle(1, 0, 0, 0, '0);

        // Wrapping run.
        cycle(0, 1, 0, 0, '0);
        for (int k = 0; k < 14; k++) cycle(1, 0, 0, 1, '0);

        // Sparse enable from idle.
        cycle(0, 1, 0, 0, '0);
        cycle(1, 0, 0, 0, '0);
        cycle(0, 0, 0, 0, '0);
        cycle(0, 0, 0, 0, '0);
        cycle(1, 0, 0, 0, '0);

        // Priority and load clamping.
        cycle(1, 0, 0, 0, '0);
        cycle(1, 1, 1, 0, 4'd7);
        cycle(1, 0, 1, 0, 4'd7);
        cycle(1, 0, 0, 0, '0);
        cycle(0, 0, 1, 0, 4'd13);
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, '0);
        cycle(0, 0, 1, 0, 4'd2);
        cycle(1, 0, 0, 0, '0);

        // Asynchronous reset between edges with counter at 5.
        cycle(0, 1, 0, 0, '0);
        for (int k = 0; k < 6; k++) cycle(1, 0, 0, 0, '0);
        #1;
        reset = 1'b1;
        #1;
        check_reset_now("async");
        #1;
        reset = 1'b0;
        model_reset();
        q_a.delete();
        q_b.delete();
        push_expected();
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, '0);

        // Randomised traffic.
        for (int k = 0; k < 500; k++) begin
            cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  AW'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
